aurora_hls_status_reader: RTL and testbench

AURORA_HLS_STATUS_READER -- requirements
Module: aurora_hls_status_reader

---
 rtl/aurora_hls_status_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_aurora_hls_status_reader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aurora_hls_status_reader.sv
// aurora_hls_status_reader
// Snapshots a bank of 32-bit status counters on request and streams them out
// as one AXI-Stream frame: a header word, then counter 0..NUM_COUNTERS-1.
// An optional trailing checksum word is the XOR of the header and all data
// words. It is enabled by defining AURORA_HLS_STATUS_READER_CHECKSUM_EN.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   counters     flat counter bus, counter i at [32*i+31:32*i]
//   req          readout request, sampled every cycle
//   m_tdata      stream data (registered)
//   m_tvalid     stream valid (registered)
//   m_tready     stream ready from the sink
//   m_tlast      marks the final word of the frame (registered)
//   busy         high whenever a frame is in progress (registered)
//   dropped_req  saturating count of requests ignored while busy
module aurora_hls_status_reader #(
  parameter int unsigned NUM_COUNTERS = 17,
  parameter logic [15:0] HEADER_MAGIC = 16'hA0A0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [32*NUM_COUNTERS-1:0] counters,
  input  logic                      req,
  output logic [31:0]               m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      busy,
  output logic [7:0]                dropped_req
);

  localparam int unsigned IW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
  localparam logic [7:0] COUNT_B = 8'(NUM_COUNTERS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_COUNTERS - 1);
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
  localparam logic HAS_CHECK = 1'b1;
`else
  localparam logic HAS_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
    , CHECK = 2'd3
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, nxt_idx;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    drop_q, drop_d;
  logic [31:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          busy_q, busy_d;
  logic          capture_en;
  logic          accept;
  logic [31:0]   snap_q [NUM_COUNTERS];
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
  logic [31:0]   csum_q, csum_d;
`endif

  assign accept  = tvalid_q & m_tready;
  assign nxt_idx = idx_q + IW'(1);

  // Next-state, datapath and output decode for the readout FSM
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    capture_en = 1'b0;
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    // Any request outside IDLE is dropped, including one coinciding with
    // final-word acceptance (state is still non-IDLE that cycle).
    if (req && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          capture_en = 1'b1;
          state_d    = HEADER;
          tvalid_d   = 1'b1;
          tdata_d    = {HEADER_MAGIC, seq_q, COUNT_B};
          tlast_d    = 1'b0;
          idx_d      = '0;
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
          csum_d     = 32'd0;
`endif
        end else begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end
      HEADER: begin
        if (accept) begin
          state_d = DATA;
          idx_d   = '0;
          tdata_d = snap_q[0];
          tlast_d = (LAST_IDX == '0) && !HAS_CHECK;
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
          csum_d  = csum_q ^ tdata_q;
`endif
        end else begin
          state_d = HEADER;
        end
      end
      DATA: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
            // Check word folds in the data word being accepted right now
            state_d = CHECK;
            tdata_d = csum_q ^ tdata_q;
            tlast_d = 1'b1;
`else
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = 32'd0;
            seq_d    = seq_q + 8'd1;
`endif
          end else begin
            idx_d   = nxt_idx;
            tdata_d = snap_q[nxt_idx];
            tlast_d = (nxt_idx == LAST_IDX) && !HAS_CHECK;
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
            csum_d  = csum_q ^ tdata_q;
`endif
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          state_d  = IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tdata_d  = 32'd0;
          seq_d    = seq_q + 8'd1;
        end else begin
          state_d = CHECK;
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = 32'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // FSM state, stream output and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      seq_q    <= 8'd0;
      drop_q   <= 8'd0;
      tdata_q  <= 32'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
      csum_q   <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Counter snapshot, loaded only when a frame starts so live changes
  // cannot leak into the frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
        snap_q[i] <= 32'd0;
      end
    end else if (capture_en) begin
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
        snap_q[i] <= counters[32*i +: 32];
      end
    end
  end

  assign m_tdata     = tdata_q;
  assign m_tvalid    = tvalid_q;
  assign m_tlast     = tlast_q;
  assign busy        = busy_q;
  assign dropped_req = drop_q;

endmodule

// File: tb/tb_aurora_hls_status_reader.sv
module tb_aurora_hls_status_reader;

  localparam int N = 17;
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
  localparam int FL = N + 2;
`else
  localparam int FL = N + 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] counters;
  logic            req;
  logic [31:0]     m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic            busy;
  logic [7:0]      dropped_req;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [7:0]  exp_seq = 8'd0;
  logic [31:0] cap [N];
  logic [31:0] last_word;

  aurora_hls_status_reader dut (
    .clk        (clk),
    .rst        (rst),
    .counters   (counters),
    .req        (req),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .dropped_req(dropped_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a negedge; leaves the bench at a negedge after the capture edge
  task automatic start_frame(input int hold);
    req = 1'b1;
    for (int i = 0; i < N; i++) cap[i] = counters[32*i +: 32];
    repeat (hold) @(negedge clk);
    req = 1'b0;
  endtask

  task automatic run_frame(input bit toggle, input bit req_at_last, input bit change_live);
    logic [31:0] exp [FL];
    int w;
    int cyc;
    bit acc;
    exp[0] = {16'hA0A0, exp_seq, 8'd17};
    for (int i = 0; i < N; i++) exp[i+1] = cap[i];
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
    exp[FL-1] = exp[0];
    for (int i = 0; i < N; i++) exp[FL-1] = exp[FL-1] ^ cap[i];
`endif
    w = 0;
    cyc = 0;
    m_tready = 1'b1;
    while (w < FL && cyc < 400) begin
      check("tvalid", 32'(m_tvalid), 32'd1);
      check("tdata", m_tdata, exp[w]);
      check("tlast", 32'(m_tlast), 32'(w == FL - 1));
      check("busy", 32'(busy), 32'd1);
      acc = m_tready;
      last_word = m_tdata;
      if (req_at_last && acc && w == FL - 1) req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      if (change_live && cyc == 0) begin
        for (int i = 0; i < N; i++) counters[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
      end
      if (acc) w++;
      if (toggle) m_tready = ~m_tready;
      cyc++;
    end
    check("frame_len", 32'(w), 32'(FL));
    check("tvalid_after", 32'(m_tvalid), 32'd0);
    check("tlast_after", 32'(m_tlast), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    exp_seq = exp_seq + 8'd1;
    m_tready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) counters[32*i +: 32] = 32'(i + 1);
    repeat (2) @(negedge clk);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dropped", 32'(dropped_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame: counters i+1, single req pulse
    start_frame(1);
    check("hdr_first", m_tdata, 32'hA0A00011);
    run_frame(1'b0, 1'b0, 1'b0);
    check("dropped_pulse", 32'(dropped_req), 32'd0);

    // Back-to-back second frame carries seq 1
    start_frame(1);
    check("hdr_second", m_tdata, 32'hA0A00111);
    run_frame(1'b0, 1'b0, 1'b0);

    // Ready toggling, live counters changed after capture
    start_frame(1);
    run_frame(1'b1, 1'b0, 1'b1);

    // req held 5 cycles while the header is stalled
    m_tready = 1'b0;
    start_frame(5);
    check("dropped_4", 32'(dropped_req), 32'd4);
    check("stall_hdr", m_tdata, {16'hA0A0, exp_seq, 8'd17});
    run_frame(1'b0, 1'b0, 1'b0);

    // Long hold saturates the drop counter
    m_tready = 1'b0;
    start_frame(300);
    check("dropped_sat", 32'(dropped_req), 32'd255);
    run_frame(1'b0, 1'b0, 1'b0);

    // Run frames until seq wraps; the 257th frame carries seq 0
    while (exp_seq != 8'd0) begin
      start_frame(1);
      run_frame(1'b0, 1'b0, 1'b0);
    end
    start_frame(1);
    check("hdr_wrap", m_tdata, 32'hA0A00011);
    run_frame(1'b0, 1'b0, 1'b0);

    // Reset while on data word 5
    start_frame(1);
    repeat (6) @(negedge clk);
    check("on_word5", m_tdata, cap[5]);
    check("on_word5_valid", 32'(m_tvalid), 32'd1);
    rst = 1'b1;
    req = 1'b1;
    #1;
    check("abort_tvalid", 32'(m_tvalid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tdata", m_tdata, 32'd0);
    check("abort_dropped", 32'(dropped_req), 32'd0);
    @(negedge clk);
    check("rst_req_busy", 32'(busy), 32'd0);
    check("rst_req_dropped", 32'(dropped_req), 32'd0);
    rst = 1'b0;
    req = 1'b0;
    exp_seq = 8'd0;
    @(negedge clk);

    // Post-reset frame with all-ones counters and a req on final acceptance
    for (int i = 0; i < N; i++) counters[32*i +: 32] = 32'h1;
    start_frame(1);
    check("hdr_after_rst", m_tdata, 32'hA0A00011);
    run_frame(1'b0, 1'b1, 1'b0);
    check("dropped_last", 32'(dropped_req), 32'd1);
`ifdef AURORA_HLS_STATUS_READER_CHECKSUM_EN
    check("check_word", last_word, 32'hA0A00010);
`else
    check("last_data", last_word, 32'h1);
`endif
    @(negedge clk);
    check("no_restart_busy", 32'(busy), 32'd0);
    check("no_restart_tvalid", 32'(m_tvalid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
